// File: rtl/pool_readout_ctrl_pkg.sv
// Shared definitions for the pooled-output readout sequencer: default geometry,
// pooling type codes and the sequencer state encoding.
package pool_readout_ctrl_pkg;

    localparam int DEF_OUTPUT_HEIGHT   = 4;
    localparam int DEF_OUTPUT_WIDTH    = 8;
    localparam int DEF_OUTPUT_SRAM_LEN = 4;
    localparam int DEF_BIN_LEN         = 8;

    localparam logic [1:0] POOL_NONE = 2'd0;
    localparam logic [1:0] POOL_MAX  = 2'd1;

    typedef enum logic [1:0] {PR_IDLE, PR_READ, PR_DRAIN, PR_DONE} pr_state_t;

    // Keeps counters at least one bit wide for degenerate geometries.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_readout_ctrl_fifo.sv
// Two-entry FIFO of {addr, data} between the array read port and the writer
// handshake; head is presented combinationally so wr_valid tracks occupancy.
module pr_skid_fifo #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [1:0]    count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       pop_ok;

    assign pop_ok = pop && (count_reg != 2'd0);

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [AW-1:0] addr_reg;
        logic [DW-1:0] data_reg;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                addr_reg <= '0;
                data_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                addr_reg <= push_addr;
                data_reg <= push_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok) rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
            // The upstream credit check must never let a push land on a full buffer.
            assert (!(push && !pop_ok && (count_reg == 2'd2)));
        end
    end

    assign valid     = (count_reg != 2'd0);
    assign count     = count_reg;
    assign head_addr = rd_ptr_reg ? g_entry[1].addr_reg : g_entry[0].addr_reg;
    assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

endmodule

// File: rtl/pool_readout_ctrl.sv
// Readout sequencer: latches pooling config, walks every (row, column-group)
// address of the pool array and streams the returned words to the SRAM writer.
module pool_readout_ctrl
    import pool_readout_ctrl_pkg::*;
#(
    parameter int OUTPUT_HEIGHT   = DEF_OUTPUT_HEIGHT,
    parameter int OUTPUT_WIDTH    = DEF_OUTPUT_WIDTH,
    parameter int OUTPUT_SRAM_LEN = DEF_OUTPUT_SRAM_LEN,
    parameter int BIN_LEN         = DEF_BIN_LEN,
    parameter int GROUPS          = OUTPUT_WIDTH / OUTPUT_SRAM_LEN,
    parameter int BEATS           = OUTPUT_HEIGHT * GROUPS,
    parameter int WADDR_W         = clog2_min1(BEATS),
    parameter int ROW_W           = clog2_min1(OUTPUT_HEIGHT),
    parameter int COL_W           = clog2_min1(OUTPUT_WIDTH),
    parameter int DATA_W          = BIN_LEN * OUTPUT_SRAM_LEN
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         cfg_pool_type,
    input  logic [2:0]         cfg_pool_stride,
    input  logic [2:0]         cfg_pool_kernel,
    output logic               finish,
    output logic [1:0]         Pool_type,
    output logic [2:0]         Pool_stride,
    output logic [2:0]         Pool_kernel_size,
    output logic               SRAM_r_en,
    output logic [ROW_W-1:0]   SRAM_r,
    output logic [COL_W-1:0]   SRAM_c,
    input  logic [DATA_W-1:0]  SRAM_out,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [WADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               busy,
    output logic               done
);

    localparam int GRP_W = clog2_min1(GROUPS);
    localparam logic [WADDR_W:0] BEATS_C = (WADDR_W+1)'(BEATS);
    localparam logic [WADDR_W:0] LAST_C  = (WADDR_W+1)'(BEATS - 1);

    pr_state_t          state_reg, state_next;
    logic [ROW_W-1:0]   r_reg, r_next;
    logic [GRP_W-1:0]   g_reg, g_next;
    logic [WADDR_W:0]   issued_reg, issued_next;
    logic [WADDR_W:0]   accepted_reg, accepted_next;
    logic               finish_reg, finish_next;
    logic [1:0]         pool_type_reg;
    logic [2:0]         pool_stride_reg, pool_kernel_reg;
    logic               inflight_reg;
    logic [WADDR_W-1:0] inflight_addr_reg;

    logic               rd_en;
    logic               pop;
    logic               room;
    logic [WADDR_W-1:0] rd_addr;
    logic [1:0]         fifo_count;

    assign pop     = wr_valid && wr_ready;
    assign rd_addr = WADDR_W'(r_reg) * WADDR_W'(GROUPS) + WADDR_W'(g_reg);
    // Occupancy after this cycle's pop plus the word already in flight must leave a slot.
    assign room    = (3'(fifo_count) + 3'(inflight_reg)) < (3'd2 + 3'(pop));

    always_comb begin
        state_next    = state_reg;
        r_next        = r_reg;
        g_next        = g_reg;
        issued_next   = issued_reg;
        accepted_next = accepted_reg + (WADDR_W+1)'(pop);
        finish_next   = finish_reg;
        rd_en         = 1'b0;
        case (state_reg)
            PR_IDLE: begin
                if (start) begin
                    state_next    = PR_READ;
                    finish_next   = 1'b1;
                    r_next        = '0;
                    g_next        = '0;
                    issued_next   = '0;
                    accepted_next = '0;
                end
            end
            PR_READ: begin
                if ((issued_reg < BEATS_C) && room) begin
                    rd_en       = 1'b1;
                    issued_next = issued_reg + (WADDR_W+1)'(1);
                    if (g_reg == GRP_W'(GROUPS - 1)) begin
                        g_next = '0;
                        r_next = r_reg + ROW_W'(1);
                    end else begin
                        g_next = g_reg + GRP_W'(1);
                    end
                    if (issued_reg == LAST_C) state_next = PR_DRAIN;
                end
            end
            PR_DRAIN: begin
                if (accepted_next == BEATS_C) state_next = PR_DONE;
            end
            PR_DONE: begin
                finish_next = 1'b0;
                state_next  = PR_IDLE;
            end
            default: state_next = PR_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= PR_IDLE;
            r_reg             <= '0;
            g_reg             <= '0;
            issued_reg        <= '0;
            accepted_reg      <= '0;
            finish_reg        <= 1'b0;
            pool_type_reg     <= '0;
            pool_stride_reg   <= '0;
            pool_kernel_reg   <= '0;
            inflight_reg      <= 1'b0;
            inflight_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            r_reg        <= r_next;
            g_reg        <= g_next;
            issued_reg   <= issued_next;
            accepted_reg <= accepted_next;
            finish_reg   <= finish_next;
            inflight_reg <= rd_en;
            if (rd_en) inflight_addr_reg <= rd_addr;
            if (start && (state_reg == PR_IDLE)) begin
                pool_type_reg   <= cfg_pool_type;
                pool_stride_reg <= cfg_pool_stride;
                pool_kernel_reg <= cfg_pool_kernel;
            end
        end
    end

    // SRAM_out is only meaningful the cycle after a read, so it is pushed only then.
    pr_skid_fifo #(
        .AW(WADDR_W),
        .DW(DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_reg),
        .push_addr (inflight_addr_reg),
        .push_data (SRAM_out),
        .pop       (pop),
        .valid     (wr_valid),
        .head_addr (wr_addr),
        .head_data (wr_data),
        .count     (fifo_count)
    );

    assign finish           = finish_reg;
    assign Pool_type        = pool_type_reg;
    assign Pool_stride      = pool_stride_reg;
    assign Pool_kernel_size = pool_kernel_reg;
    assign SRAM_r_en        = rd_en;
    assign SRAM_r           = r_reg;
    assign SRAM_c           = COL_W'(g_reg) * COL_W'(OUTPUT_SRAM_LEN);
    assign busy             = (state_reg != PR_IDLE);
    assign done             = (state_reg == PR_DONE);

endmodule

// File: tb/tb_pool_readout_ctrl.sv
// Randomized bench for pool_readout_ctrl: a random array image feeds a 1-cycle
// read-port model, and the accepted stream is compared against row-major order.
module tb_pool_readout_ctrl;
    import pool_readout_ctrl_pkg::*;

    localparam int H = 4, W = 8, LEN = 4, BL = 8;
    localparam int GROUPS = W / LEN, BEATS = H * GROUPS;
    localparam int AW = 3, DW = BL * LEN;

    logic          clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic [1:0]    cfg_pool_type = '0;
    logic [2:0]    cfg_pool_stride = '0, cfg_pool_kernel = '0;
    logic          finish, SRAM_r_en, wr_valid, busy, done;
    logic          wr_ready = 1'b0;
    logic [1:0]    Pool_type;
    logic [2:0]    Pool_stride, Pool_kernel_size;
    logic [1:0]    SRAM_r;
    logic [2:0]    SRAM_c;
    logic [DW-1:0] SRAM_out = '0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    pool_readout_ctrl #(
        .OUTPUT_HEIGHT(H), .OUTPUT_WIDTH(W), .OUTPUT_SRAM_LEN(LEN), .BIN_LEN(BL)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .cfg_pool_type(cfg_pool_type), .cfg_pool_stride(cfg_pool_stride),
        .cfg_pool_kernel(cfg_pool_kernel), .finish(finish),
        .Pool_type(Pool_type), .Pool_stride(Pool_stride), .Pool_kernel_size(Pool_kernel_size),
        .SRAM_r_en(SRAM_r_en), .SRAM_r(SRAM_r), .SRAM_c(SRAM_c), .SRAM_out(SRAM_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #10 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [BL-1:0] image [H][W];

    task automatic new_image();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                image[r][c] = 8'($urandom);
    endtask

    // Expected word for linear index: row-major walk, element 0 in the low bits.
    function automatic logic [DW-1:0] model_word(input int idx);
        logic [DW-1:0] w;
        int r, c0;
        r  = idx / GROUPS;
        c0 = (idx % GROUPS) * LEN;
        for (int k = 0; k < LEN; k++) w[k*BL +: BL] = image[r][c0 + k];
        return w;
    endfunction

    // Pool array registered read port; garbage outside the read-data cycle.
    always @(posedge clock) begin
        if (SRAM_r_en) begin
            for (int k = 0; k < LEN; k++) begin
                if (int'(SRAM_c) + k < W) SRAM_out[k*BL +: BL] <= image[SRAM_r][int'(SRAM_c) + k];
                else SRAM_out[k*BL +: BL] <= '0;
            end
        end else begin
            SRAM_out <= $urandom;
        end
    end

    int ready_mode = 0;   // 0 high, 1 toggle, 2 random, 3 low
    initial forever begin
        @(negedge clock);
        case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ~wr_ready;
            2:       wr_ready = 1'($urandom_range(0, 1));
            default: wr_ready = 1'b0;
        endcase
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    beat_t         got[$];
    int            done_q[$];
    int            c_seq[$];
    int            reads, accepted_cnt, stall_err, credit_err, first_valid_cyc;
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    task automatic clear_obs();
        got.delete(); done_q.delete(); c_seq.delete();
        reads = 0; accepted_cnt = 0; stall_err = 0; credit_err = 0;
        first_valid_cyc = -1; prev_stall = 1'b0;
    endtask

    // Observer samples late in the low phase, after inputs settle for the next edge.
    initial forever begin
        @(negedge clock);
        #3;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(wr_valid && wr_addr == prev_addr && wr_data == prev_data))
                stall_err++;
            if (SRAM_r_en) begin
                if (reads + 1 - accepted_cnt - int'(wr_valid && wr_ready) > 2) credit_err++;
                reads++;
                c_seq.push_back(int'(SRAM_c));
            end
            if (wr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (wr_valid && wr_ready) begin
                got.push_back('{addr: wr_addr, data: wr_data, cyc: cyc});
                accepted_cnt++;
            end
            if (done) done_q.push_back(cyc);
            prev_stall = wr_valid && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end
    end

    task automatic pulse_start(input logic [1:0] t, input logic [2:0] s, input logic [2:0] k,
                               output int scyc);
        @(negedge clock);
        start = 1'b1; cfg_pool_type = t; cfg_pool_stride = s; cfg_pool_kernel = k;
        scyc = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        timed_out = (done_q.size() == 0);
        repeat (3) @(negedge clock);
        #4;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        @(negedge clock); #4;
        checks++;
        if ({finish, busy, done, wr_valid, SRAM_r_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {finish, busy, done, wr_valid, SRAM_r_en});
        end
        checks++;
        if ({wr_addr, wr_data, SRAM_r, SRAM_c} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d data=%h r=%0d c=%0d want all 0", wr_addr, wr_data, SRAM_r, SRAM_c);
        end
        checks++;
        if ({Pool_type, Pool_stride, Pool_kernel_size} !== 8'h00) begin
            errors++;
            $display("FAIL reset_cfg: got %h want 00", {Pool_type, Pool_stride, Pool_kernel_size});
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_stream();
        int scyc; bit to;
        new_image(); clear_obs(); ready_mode = 0;
        pulse_start(POOL_NONE, 3'd1, 3'd1, scyc);
        wait_done(200, to);
        checks++;
        if (to) begin errors++; $display("FAIL stream_done_timeout: no done within budget"); end
        checks++;
        if (got.size() !== BEATS) begin errors++; $display("FAIL stream_count: got %0d words want %0d", got.size(), BEATS); end
        for (int i = 0; i < got.size() && i < BEATS; i++) begin
            checks++;
            if (got[i].addr !== AW'(i) || got[i].data !== model_word(i) || got[i].cyc !== got[0].cyc + i) begin
                errors++;
                $display("FAIL stream_beat%0d: addr=%0d data=%h cyc+%0d want addr=%0d data=%h cyc+%0d",
                         i, got[i].addr, got[i].data, got[i].cyc - got[0].cyc, i, model_word(i), i);
            end
        end
        checks++;
        if (first_valid_cyc - scyc > 3 || first_valid_cyc <= scyc) begin
            errors++; $display("FAIL stream_latency: %0d cycles want 1..3", first_valid_cyc - scyc);
        end
        for (int i = 0; i < c_seq.size(); i++) begin
            checks++;
            if (c_seq[i] !== (i % GROUPS) * LEN) begin
                errors++; $display("FAIL stream_col%0d: SRAM_c=%0d want %0d", i, c_seq[i], (i % GROUPS) * LEN);
            end
        end
        checks++;
        if (done_q.size() !== 1 || got.size() !== BEATS || done_q[0] !== got[BEATS-1].cyc + 1) begin
            errors++; $display("FAIL stream_done_timing: %0d done pulses, want one exactly 1 cycle after last beat", done_q.size());
        end
        checks++;
        if ({finish, busy} !== 2'b00) begin errors++; $display("FAIL stream_idle: finish,busy=%b want 00", {finish, busy}); end
    endtask

    task automatic test_backpressure(input int mode, input string name);
        int scyc; bit to;
        new_image(); clear_obs(); ready_mode = mode;
        pulse_start(POOL_NONE, 3'd1, 3'd1, scyc);
        wait_done(400, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_done_timeout: no done within budget", name); end
        checks++;
        if (got.size() !== BEATS) begin errors++; $display("FAIL %s_count: got %0d words want %0d", name, got.size(), BEATS); end
        for (int i = 0; i < got.size() && i < BEATS; i++) begin
            checks++;
            if (got[i].addr !== AW'(i) || got[i].data !== model_word(i)) begin
                errors++;
                $display("FAIL %s_beat%0d: addr=%0d data=%h want addr=%0d data=%h", name, i, got[i].addr, got[i].data, i, model_word(i));
            end
        end
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL %s_stall_stable: %0d changes while stalled want 0", name, stall_err); end
        checks++;
        if (credit_err !== 0 || reads !== BEATS) begin
            errors++; $display("FAIL %s_reads: overcommit=%0d reads=%0d want 0 and %0d", name, credit_err, reads, BEATS);
        end
        checks++;
        if (done_q.size() !== 1) begin errors++; $display("FAIL %s_done_count: %0d want 1", name, done_q.size()); end
        ready_mode = 0;
    endtask

    task automatic test_config_hold();
        int scyc, n; bit to;
        new_image(); clear_obs(); ready_mode = 2;
        pulse_start(POOL_MAX, 3'd2, 3'd2, scyc);
        n = 0;
        while (done_q.size() == 0 && n < 200) begin
            @(negedge clock);
            cfg_pool_type = 2'($urandom); cfg_pool_stride = 3'($urandom); cfg_pool_kernel = 3'($urandom);
            #4;
            checks++;
            if ({Pool_type, Pool_stride, Pool_kernel_size, finish} !== {POOL_MAX, 3'd2, 3'd2, 1'b1}) begin
                errors++;
                $display("FAIL cfg_hold: type=%0d stride=%0d kernel=%0d finish=%b want 1 2 2 1",
                         Pool_type, Pool_stride, Pool_kernel_size, finish);
            end
            n++;
        end
        wait_done(10, to);
        checks++;
        if (to || got.size() !== BEATS) begin errors++; $display("FAIL cfg_run: words=%0d want %0d", got.size(), BEATS); end
        checks++;
        if ({Pool_type, Pool_stride, Pool_kernel_size} !== {POOL_MAX, 3'd2, 3'd2}) begin
            errors++; $display("FAIL cfg_after_done: got %0d %0d %0d want 1 2 2", Pool_type, Pool_stride, Pool_kernel_size);
        end
        ready_mode = 0;
    endtask

    task automatic test_second_start();
        int scyc, dummy, n; bit to;
        new_image(); clear_obs(); ready_mode = 0;
        pulse_start(POOL_NONE, 3'd3, 3'd4, scyc);
        n = 0;
        while (got.size() < 3 && n < 100) begin @(negedge clock); #4; n++; end
        pulse_start(POOL_MAX, 3'd7, 3'd7, dummy);
        wait_done(200, to);
        repeat (10) @(negedge clock);
        #4;
        checks++;
        if (to || done_q.size() !== 1) begin errors++; $display("FAIL restart_done: %0d done pulses want 1", done_q.size()); end
        checks++;
        if (got.size() !== BEATS) begin errors++; $display("FAIL restart_count: got %0d words want %0d", got.size(), BEATS); end
        for (int i = 0; i < got.size() && i < BEATS; i++) begin
            checks++;
            if (got[i].addr !== AW'(i) || got[i].data !== model_word(i)) begin
                errors++; $display("FAIL restart_beat%0d: addr=%0d data=%h want addr=%0d data=%h", i, got[i].addr, got[i].data, i, model_word(i));
            end
        end
        checks++;
        if ({Pool_stride, Pool_kernel_size, busy} !== {3'd3, 3'd4, 1'b0}) begin
            errors++; $display("FAIL restart_cfg: stride=%0d kernel=%0d busy=%b want 3 4 0", Pool_stride, Pool_kernel_size, busy);
        end
    endtask

    task automatic test_reset_mid();
        int scyc, n; bit to;
        new_image(); clear_obs(); ready_mode = 0;
        pulse_start(POOL_MAX, 3'd2, 3'd2, scyc);
        n = 0;
        while (!(got.size() >= 5 && wr_valid) && n < 100) begin @(negedge clock); #4; n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL midreset_reach: beat 5 not reached, words=%0d", got.size()); end
        reset = 1'b1;
        #1;
        checks++;
        if ({finish, busy, done, wr_valid, SRAM_r_en, wr_addr, wr_data, SRAM_r, SRAM_c,
             Pool_type, Pool_stride, Pool_kernel_size} !== '0) begin
            errors++;
            $display("FAIL midreset_async: finish=%b busy=%b valid=%b ren=%b addr=%0d data=%h type=%0d want all 0",
                     finish, busy, wr_valid, SRAM_r_en, wr_addr, wr_data, Pool_type);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        #4;
        checks++;
        if (done_q.size() !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_nodone: done pulses=%0d busy=%b want 0 0", done_q.size(), busy);
        end
        clear_obs();
        pulse_start(POOL_NONE, 3'd1, 3'd1, scyc);
        wait_done(200, to);
        checks++;
        if (to || got.size() !== BEATS) begin errors++; $display("FAIL midreset_rerun_count: got %0d words want %0d", got.size(), BEATS); end
        for (int i = 0; i < got.size() && i < BEATS; i++) begin
            checks++;
            if (got[i].addr !== AW'(i) || got[i].data !== model_word(i)) begin
                errors++; $display("FAIL midreset_beat%0d: addr=%0d data=%h want addr=%0d data=%h", i, got[i].addr, got[i].data, i, model_word(i));
            end
        end
    endtask

    task automatic test_long_stall();
        int scyc; bit to;
        new_image(); clear_obs(); ready_mode = 3;
        pulse_start(POOL_NONE, 3'd1, 3'd1, scyc);
        repeat (20) @(negedge clock);
        #4;
        checks++;
        if (reads > 2) begin errors++; $display("FAIL stall_reads: %0d reads issued want <= 2", reads); end
        checks++;
        if ({wr_valid, busy, finish} !== 3'b111 || wr_addr !== AW'(0) || wr_data !== model_word(0)) begin
            errors++;
            $display("FAIL stall_head: valid=%b busy=%b finish=%b addr=%0d data=%h want 1 1 1 0 %h",
                     wr_valid, busy, finish, wr_addr, wr_data, model_word(0));
        end
        ready_mode = 0;
        wait_done(200, to);
        checks++;
        if (to || got.size() !== BEATS) begin errors++; $display("FAIL stall_release_count: got %0d words want %0d", got.size(), BEATS); end
        for (int i = 0; i < got.size() && i < BEATS; i++) begin
            checks++;
            if (got[i].addr !== AW'(i) || got[i].data !== model_word(i)) begin
                errors++; $display("FAIL stall_beat%0d: addr=%0d data=%h want addr=%0d data=%h", i, got[i].addr, got[i].data, i, model_word(i));
            end
        end
        checks++;
        if (stall_err !== 0 || done_q.size() !== 1) begin
            errors++; $display("FAIL stall_integrity: unstable=%0d done=%0d want 0 1", stall_err, done_q.size());
        end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_stream();
        test_backpressure(1, "toggle");
        for (int i = 0; i < 3; i++) test_backpressure(2, "random");
        test_config_hold();
        test_second_start();
        test_reset_mid();
        test_long_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pool_readout_ctrl.md
Name: pool_readout_ctrl

Overview:
Sequences the pooled-output readout after a convolution pass completes.
- Latches the pooling configuration and holds `finish` high to the pool array.
- Walks every (row, column-group) read address into the array's registered read port, which has 1-cycle latency.
- Streams the returned words into the output-SRAM writer over a valid/ready handshake, with a 2-entry buffer so backpressure never drops data.
- Sits between the layer controller (start/done) and the pool array / output SRAM writer.

Parameters:
OUTPUT_HEIGHT, `OUTPUT_HEIGHT, rows in the array
OUTPUT_WIDTH, `OUTPUT_WIDTH, columns in the array; must be a multiple of OUTPUT_SRAM_LEN
OUTPUT_SRAM_LEN, `OUTPUT_SRAM_LEN, elements per SRAM word
BIN_LEN, `BIN_LEN, bits per stored element
GROUPS, OUTPUT_WIDTH/OUTPUT_SRAM_LEN, derived: words per row
BEATS, OUTPUT_HEIGHT*GROUPS, derived: words per layer
WADDR_W, $clog2(BEATS), output word-address width

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: accumulation finished, begin readout
cfg_pool_type  in  2  POOL_NONE/POOL_MAX, latched on accepted start
cfg_pool_stride  in  3  latched on accepted start
cfg_pool_kernel  in  3  latched on accepted start
finish  out  1  to pool array; high from accepted start until done
Pool_type / Pool_stride / Pool_kernel_size  out  2/3/3  latched config to pool array
SRAM_r_en  out  1  array read enable
SRAM_r  out  $clog2(OUTPUT_HEIGHT)  array read row
SRAM_c  out  $clog2(OUTPUT_WIDTH)  array read start column, always g*OUTPUT_SRAM_LEN
SRAM_out  in  BIN_LEN*OUTPUT_SRAM_LEN  array data, valid the cycle after SRAM_r_en
wr_valid  out  1  word available to writer
wr_ready  in  1  writer accepts when wr_valid && wr_ready
wr_addr  out  WADDR_W  linear word index, r*GROUPS+g
wr_data  out  BIN_LEN*OUTPUT_SRAM_LEN  word payload
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
Reset values:
- All outputs 0, state IDLE, buffer empty, counters 0, config registers 0.
- A reset mid-operation aborts immediately; no done pulse is produced.

State machine:
- IDLE: an accepted start (start && !busy) latches the cfg_* inputs, sets finish, and goes to READ. A start while busy is ignored.
- READ: issue SRAM_r_en=1 with the current (r,g) when issued < BEATS and (buffer count + in-flight) < 2.
  - Advance g; on g==GROUPS-1, wrap g to 0 and increment r.
  - After issuing read BEATS-1, stop issuing and go to DRAIN.
- DRAIN: wait until accepted == BEATS, then go to DONE.
- DONE: pulse done for 1 cycle, clear finish, return to IDLE.
- One cycle of gap between the READ entry and the first SRAM_r_en is allowed. This lets finish propagate through the combinational pooling.

Data path:
- On the cycle after SRAM_r_en, capture SRAM_out together with its address into the buffer tail.
- SRAM_out is never sampled on any other cycle, because it is high-Z outside the read cycle.
- Buffer: 2-entry FIFO; wr_valid = !empty; wr_data/wr_addr come from the head.
- A simultaneous push and pop leaves the count unchanged.
- The credit rule above guarantees no overflow. Asserting overflow is a verification check.
- wr_data and wr_addr must stay stable while wr_valid && !wr_ready.

Throughput:
- With wr_ready held high, one word per cycle.
- Latency from the accepted start to the first wr_valid is ≤3 cycles.

Counters:
- issued and accepted are WADDR_W+1 bits wide.
- wr_addr is derived from the captured r and g, not from the accepted counter.

Decomposition:
- The shared package sys_defs.svh supplies the POOL_NONE/POOL_MAX codes, BIN_LEN, OUTPUT_* and OUTPUT_SRAM_LEN macros.
- Add to it a state enum pr_state_t {PR_IDLE, PR_READ, PR_DRAIN, PR_DONE}.
- One sub-module: pr_skid_fifo, a parameterised 2-entry FIFO of {addr, data} with push/pop/count.

Test Plan:
1. H=4, W=8, LEN=4, wr_ready=1, start pulse → 8 words at wr_addr 0..7 on consecutive cycles; SRAM_c alternates 0,4; done exactly 1 cycle after the beat-7 handshake; finish low afterward.
2. Same config, wr_ready toggling 1,0,1,0 → no lost or duplicated word; SRAM_r_en pauses while the buffer is full; wr_data stable while stalled; data matches the array image.
3. cfg_pool_type=POOL_MAX, stride=2, kernel=2 presented at start, then changed mid-run → Pool_* outputs keep the start values until done.
4. A second start pulse at beat 3 → ignored; exactly 8 words; a single done.
5. Async reset asserted at beat 5 while wr_valid=1 → all outputs 0 immediately, without waiting for a clock edge; no done; a fresh start afterward produces the full sequence 0..7.
6. wr_ready=0 for 20 cycles after start → at most 2 reads issued, wr_valid held with addr 0, busy=1; releasing wr_ready completes normally.
